// File: rtl/fpa_normalize_round.sv
// Single-precision normalize-and-round back end for a floating-point adder.
// Stage 1 normalizes the raw sum, stage 2 rounds to nearest-even and packs.
module fpa_normalize_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        In_Valid,
    output logic        In_Ready,
    input  logic [27:0] Calculation_Frac,
    input  logic [7:0]  Large_Exp,
    input  logic        Result_Sign,
    output logic        Out_Valid,
    input  logic        Out_Ready,
    output logic [31:0] Result,
    output logic        Flag_Overflow,
    output logic        Flag_Underflow,
    output logic        Flag_Inexact
);

    logic               s1_valid;
    logic               s1_zero;
    logic               s1_sign;
    logic signed [9:0]  s1_exp;
    logic [26:0]        s1_frac;
    logic               s2_valid;
    logic               s2_ready;

    logic [4:0]         lzc;
    logic [26:0]        norm_frac;
    logic signed [9:0]  norm_exp;

    logic               round_up;
    logic [23:0]        mant_sum;
    logic signed [9:0]  fin_exp;
    logic [31:0]        pack_result;
    logic               pack_ovf;
    logic               pack_unf;
    logic               pack_inx;

    // Stage 2 frees up when empty or drained; stage 1 frees up whenever stage 2 can take its beat.
    assign s2_ready  = !s2_valid || Out_Ready;
    assign In_Ready  = !s1_valid || s2_ready;
    assign Out_Valid = s2_valid;

    always_comb begin
        lzc = '0;
        for (int i = 0; i < 27; i++) begin
            if (Calculation_Frac[i]) lzc = 5'(26 - i);
        end
        norm_frac = Calculation_Frac[26:0] << lzc;
        norm_exp  = signed'({2'b00, Large_Exp}) - signed'({5'b00000, lzc});
        if (Calculation_Frac[27]) begin
            norm_frac = {Calculation_Frac[27:2], Calculation_Frac[1] | Calculation_Frac[0]};
            norm_exp  = signed'({2'b00, Large_Exp}) + 10'sd1;
        end
    end

    always_comb begin
        round_up    = s1_frac[2] & (s1_frac[1] | s1_frac[0] | s1_frac[3]);
        mant_sum    = {1'b0, s1_frac[25:3]} + {23'd0, round_up};
        fin_exp     = s1_exp + signed'({9'd0, mant_sum[23]});
        pack_result = {s1_sign, fin_exp[7:0], mant_sum[22:0]};
        pack_ovf    = 1'b0;
        pack_unf    = 1'b0;
        pack_inx    = |s1_frac[2:0];
        if (s1_zero) begin
            pack_result = 32'h0000_0000;
            pack_inx    = 1'b0;
        end else if (fin_exp >= 10'sd255) begin
            pack_result = {s1_sign, 8'hFF, 23'h0};
            pack_ovf    = 1'b1;
            pack_inx    = 1'b1;
        end else if (fin_exp <= 10'sd0) begin
            pack_result = {s1_sign, 31'h0};
            pack_unf    = 1'b1;
        end
    end

    // NOTE: payload registers are reset too, because Result and the flags must read 0 during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_zero  <= 1'b0;
            s1_sign  <= 1'b0;
            s1_exp   <= '0;
            s1_frac  <= '0;
        end else if (In_Ready) begin
            s1_valid <= In_Valid;
            if (In_Valid) begin
                s1_zero <= (Calculation_Frac == 28'd0);
                s1_sign <= Result_Sign;
                s1_exp  <= norm_exp;
                s1_frac <= norm_frac;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid       <= 1'b0;
            Result         <= '0;
            Flag_Overflow  <= 1'b0;
            Flag_Underflow <= 1'b0;
            Flag_Inexact   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                Result         <= pack_result;
                Flag_Overflow  <= pack_ovf;
                Flag_Underflow <= pack_unf;
                Flag_Inexact   <= pack_inx;
            end
        end
    end

endmodule

// File: tb/tb_fpa_normalize_round.sv
// Self-checking bench for fpa_normalize_round: directed vectors, randomized
// traffic against an arithmetic reference model, stall and mid-stream reset.
module tb_fpa_normalize_round;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        In_Valid = 1'b0;
    logic        In_Ready;
    logic [27:0] Calculation_Frac = '0;
    logic [7:0]  Large_Exp = 8'h7F;
    logic        Result_Sign = 1'b0;
    logic        Out_Valid;
    logic        Out_Ready = 1'b0;
    logic [31:0] Result;
    logic        Flag_Overflow;
    logic        Flag_Underflow;
    logic        Flag_Inexact;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpa_normalize_round dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .In_Valid         (In_Valid),
        .In_Ready         (In_Ready),
        .Calculation_Frac (Calculation_Frac),
        .Large_Exp        (Large_Exp),
        .Result_Sign      (Result_Sign),
        .Out_Valid        (Out_Valid),
        .Out_Ready        (Out_Ready),
        .Result           (Result),
        .Flag_Overflow    (Flag_Overflow),
        .Flag_Underflow   (Flag_Underflow),
        .Flag_Inexact     (Flag_Inexact)
    );

    // {frac, exp, sign, result, {ovf, unf, inx}}
    typedef struct packed {
        logic [27:0] frac;
        logic [7:0]  exp;
        logic        sign;
        logic [31:0] res;
        logic [2:0]  flags;
    } vec_t;

    localparam vec_t VECS [10] = '{
        {28'h8000000, 8'h7F, 1'b0, 32'h40000000, 3'b000},
        {28'h4000000, 8'h7F, 1'b0, 32'h3F800000, 3'b000},
        {28'h0000000, 8'h7F, 1'b0, 32'h00000000, 3'b000},
        {28'h0000000, 8'h7F, 1'b1, 32'h00000000, 3'b000},
        {28'h4000004, 8'h7F, 1'b0, 32'h3F800000, 3'b001},
        {28'h400000C, 8'h7F, 1'b0, 32'h3F800002, 3'b001},
        {28'h8000000, 8'hFE, 1'b0, 32'h7F800000, 3'b101},
        {28'h0000008, 8'h10, 1'b0, 32'h00000000, 3'b010},
        {28'h7FFFFFC, 8'h7F, 1'b0, 32'h40000000, 3'b001},
        {28'h4000000, 8'h7F, 1'b1, 32'hBF800000, 3'b000}
    };

    // Reference: value = frac * 2^(exp-153); round to 24 significant bits, nearest-even.
    // Returns {ovf, unf, inx, result}.
    function automatic logic [34:0] model(input logic [27:0] f, input logic [7:0] e, input logic s);
        longint fv, m, rem, half;
        int     p, ex, d;
        logic   inx;
        fv = longint'(f);
        if (fv == 0) return '0;
        p = 0;
        for (int i = 0; i < 28; i++) if (f[i]) p = i;
        ex  = int'(e) + p - 26;
        d   = p - 23;
        inx = 1'b0;
        if (d > 0) begin
            m    = fv >> d;
            rem  = fv - (m << d);
            half = longint'(1) << (d - 1);
            inx  = (rem != 0);
            if (rem > half || (rem == half && m[0])) m = m + 1;
            if (m == (longint'(1) << 24)) begin
                m  = m >> 1;
                ex = ex + 1;
            end
        end else begin
            m = fv << (-d);
        end
        if (ex >= 255) return {3'b101, s, 8'hFF, 23'h0};
        if (ex <= 0)   return {2'b01, inx, s, 31'h0};
        return {2'b00, inx, s, 8'(ex), m[22:0]};
    endfunction

    function automatic logic [27:0] rand_frac();
        int k;
        k = $urandom_range(28, 0);
        if (k == 0) return '0;
        return 28'($urandom >> (32 - k));
    endfunction

    function automatic logic [7:0] rand_exp();
        case ($urandom_range(3, 0))
            0:       return 8'($urandom_range(254, 240));
            1:       return 8'($urandom_range(30, 1));
            default: return 8'($urandom_range(254, 1));
        endcase
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", Out_Valid); end
        checks++; if (Result !== 32'h0) begin errors++; $display("FAIL reset_result got=%h want=00000000", Result); end
        checks++; if ({Flag_Overflow, Flag_Underflow, Flag_Inexact} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got=%b want=000", {Flag_Overflow, Flag_Underflow, Flag_Inexact}); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", In_Ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        Out_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            Calculation_Frac = VECS[i].frac;
            Large_Exp = VECS[i].exp;
            Result_Sign = VECS[i].sign;
            In_Valid = 1'b1;
            #1;
            checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready got=%b want=1", i, In_Ready); end
            @(negedge clk);
            In_Valid = 1'b0;
            checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid got=%b want=0", i, Out_Valid); end
            @(negedge clk);
            checks++; if (Out_Valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency got=%b want=1", i, Out_Valid); end
            checks++; if (Result !== VECS[i].res) begin errors++; $display("FAIL dir%0d_result got=%h want=%h", i, Result, VECS[i].res); end
            checks++; if ({Flag_Overflow, Flag_Underflow, Flag_Inexact} !== VECS[i].flags) begin
                errors++; $display("FAIL dir%0d_flags got=%b want=%b", i, {Flag_Overflow, Flag_Underflow, Flag_Inexact}, VECS[i].flags); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [34:0] q[$];
        logic [34:0] want;
        Out_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i < 8) begin
                Calculation_Frac = rand_frac();
                Large_Exp = rand_exp();
                Result_Sign = 1'($urandom_range(1, 0));
                In_Valid = 1'b1;
                q.push_back(model(Calculation_Frac, Large_Exp, Result_Sign));
            end else begin
                In_Valid = 1'b0;
            end
            #1;
            if (i < 8) begin
                checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_in_ready got=%b want=1", i, In_Ready); end
            end
            if (i >= 2) begin
                want = q.pop_front();
                checks++; if (Out_Valid !== 1'b1 || {Flag_Overflow, Flag_Underflow, Flag_Inexact, Result} !== want) begin
                    errors++; $display("FAIL b2b%0d_out valid=%b got=%h want=%h", i, Out_Valid,
                                       {Flag_Overflow, Flag_Underflow, Flag_Inexact, Result}, want); end
            end
        end
    endtask

    task automatic test_random();
        logic [34:0] q[$];
        logic [34:0] want;
        int   sent = 0;
        int   cyc = 0;
        logic acc = 1'b0;
        In_Valid = 1'b0;
        while ((sent < 300 || q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            Out_Ready = ($urandom_range(3, 0) != 0);
            if (acc || !In_Valid) begin
                if (sent < 300 && $urandom_range(3, 0) != 0) begin
                    Calculation_Frac = rand_frac();
                    Large_Exp = rand_exp();
                    Result_Sign = 1'($urandom_range(1, 0));
                    In_Valid = 1'b1;
                end else begin
                    In_Valid = 1'b0;
                end
            end
            #1;
            if (Out_Valid && Out_Ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_spurious got=%h want=none", Result);
                end else begin
                    want = q.pop_front();
                    if ({Flag_Overflow, Flag_Underflow, Flag_Inexact, Result} !== want) begin
                        errors++; $display("FAIL rand_result got=%h want=%h", {Flag_Overflow, Flag_Underflow, Flag_Inexact, Result}, want); end
                end
            end
            acc = In_Valid && In_Ready;
            if (acc) begin
                q.push_back(model(Calculation_Frac, Large_Exp, Result_Sign));
                sent++;
            end
        end
        checks++; if (cyc >= 20000) begin errors++; $display("FAIL rand_timeout got=%0d pending want=0", q.size()); end
        @(negedge clk);
        In_Valid = 1'b0;
        Out_Ready = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_stall();
        logic [31:0] want [3] = '{32'h40000000, 32'h3F800000, 32'h3F800002};
        int   got = 0;
        logic acc = 1'b0;
        Out_Ready = 1'b0;
        @(negedge clk);
        Calculation_Frac = 28'h8000000; Large_Exp = 8'h7F; Result_Sign = 1'b0; In_Valid = 1'b1;
        #1;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL stall_a_ready got=%b want=1", In_Ready); end
        @(negedge clk);
        Calculation_Frac = 28'h4000000;
        #1;
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL stall_b_ready got=%b want=1", In_Ready); end
        @(negedge clk);
        Calculation_Frac = 28'h400000C;
        #1;
        checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got=%b want=0", In_Ready); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            checks++; if (Out_Valid !== 1'b1 || Result !== want[0] || In_Ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d valid=%b ready=%b got=%h want=%h", c, Out_Valid, In_Ready, Result, want[0]); end
        end
        for (int c = 0; c < 10 && got < 3; c++) begin
            @(negedge clk);
            Out_Ready = 1'b1;
            if (acc) In_Valid = 1'b0;
            #1;
            acc = In_Valid && In_Ready;
            if (Out_Valid) begin
                checks++; if (Result !== want[got]) begin
                    errors++; $display("FAIL stall_drain%0d got=%h want=%h", got, Result, want[got]); end
                got++;
            end
        end
        @(negedge clk);
        In_Valid = 1'b0;
        checks++; if (got !== 3) begin errors++; $display("FAIL stall_count got=%0d want=3", got); end
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL stall_duplicate got=%b want=0", Out_Valid); end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        Out_Ready = 1'b1;
        @(negedge clk);
        Calculation_Frac = 28'h8000000; Large_Exp = 8'h7F; Result_Sign = 1'b0; In_Valid = 1'b1;
        @(negedge clk);
        Calculation_Frac = 28'h4000000;
        @(negedge clk);
        In_Valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b want=0", Out_Valid); end
        checks++; if ({Flag_Overflow, Flag_Underflow, Flag_Inexact, Result} !== 35'h0) begin
            errors++; $display("FAIL midrst_outputs got=%h want=0", {Flag_Overflow, Flag_Underflow, Flag_Inexact, Result}); end
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b want=1", In_Ready); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (Out_Valid !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_stale got=%0d want=0", seen); end
        @(negedge clk);
        Calculation_Frac = 28'h400000C; Large_Exp = 8'h80; Result_Sign = 1'b1; In_Valid = 1'b1;
        @(negedge clk);
        In_Valid = 1'b0;
        checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL midrst_early got=%b want=0", Out_Valid); end
        @(negedge clk);
        checks++; if (Out_Valid !== 1'b1 || Result !== 32'hC0000002) begin
            errors++; $display("FAIL midrst_first valid=%b got=%h want=c0000002", Out_Valid, Result); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_stall();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fpa_normalize_round.md
FPA_NORMALIZE_ROUND -- requirements
Module: fpa_normalize_round

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed for IEEE-754 single precision.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide, and is the asynchronous active-low reset.
REQ-004 The port In_Valid SHALL be an input, 1 bit wide, indicating the input beat is valid.
REQ-005 The port In_Ready SHALL be an output, 1 bit wide, indicating the block accepts an input beat this cycle.
REQ-006 The port Calculation_Frac SHALL be an input, 28 bits wide, carrying the raw add/sub fraction: bit 27 is carry, bit 26 is the hidden-bit position, bits 2:0 are guard/round/sticky.
REQ-007 The port Large_Exp SHALL be an input, 8 bits wide, carrying the biased exponent of the larger operand, in the range 1..254.
REQ-008 The port Result_Sign SHALL be an input, 1 bit wide, carrying the sign of the result.
REQ-009 The port Out_Valid SHALL be an output, 1 bit wide, indicating the output beat is valid.
REQ-010 The port Out_Ready SHALL be an input, 1 bit wide, indicating downstream accepts the output beat.
REQ-011 The port Result SHALL be an output, 32 bits wide, carrying the packed single-precision result.
REQ-012 The ports Flag_Overflow, Flag_Underflow and Flag_Inexact SHALL each be an output, 1 bit wide, and are qualified by Out_Valid.

Function
REQ-013 The block SHALL be a 2-stage elastic pipeline: stage 1 normalizes, stage 2 rounds and packs; latency SHALL be 2 cycles from accepted input to Out_Valid when not stalled.
REQ-014 A transfer SHALL occur on an input or output port only when its Valid and Ready are both high at a rising edge.
REQ-015 Each stage SHALL advance when it is empty or when its downstream consumes it.
REQ-016 In_Ready SHALL equal (!s1_valid || s1_advance), and SHALL NOT depend combinationally on In_Valid.
REQ-017 Full throughput SHALL be 1 beat per cycle with Out_Ready held high.
REQ-018 While Out_Valid=1 and Out_Ready=0, Result and all flags SHALL be held stable, and no beat SHALL be dropped or duplicated.
REQ-019 Stage 1, carry case: if Calculation_Frac[27]=1, the fraction SHALL be shifted right 1 with the dropped bit ORed into sticky, and the exponent SHALL be incremented by 1.
REQ-020 Stage 1, no-carry case: otherwise the fraction SHALL be shifted left by the leading-zero count of bits [26:0], and the exponent SHALL be decremented by that count.
REQ-021 Stage 1 SHALL use a 10-bit signed internal exponent.
REQ-022 Stage 1, zero case: if Calculation_Frac=0, the beat SHALL be marked zero and the result SHALL be +0 (0x00000000) with all flags 0.
REQ-023 Stage 2 SHALL interpret the normalized value N[26:0] as: N[26] hidden, N[25:3] mantissa, N[2] G, N[1] R, N[0] S.
REQ-024 Stage 2 SHALL round up when G && (R || S || N[3]), i.e. round-to-nearest-even.
REQ-025 Flag_Inexact SHALL equal G|R|S.
REQ-026 If rounding carries out of the mantissa, the mantissa SHALL become 0 and the exponent SHALL be incremented by 1.
REQ-027 If the final exponent is >= 255, Result SHALL be {sign, 8'hFF, 23'h0} with Flag_Overflow=1 and Flag_Inexact=1.
REQ-028 If the final exponent is <= 0, Result SHALL be {sign, 31'h0} with Flag_Underflow=1 (flush to zero; no denormals).
REQ-029 Exponent range checks SHALL apply after rounding.

Reset
REQ-030 Assertion of rst_n=0 SHALL asynchronously clear both stage valid bits, forcing Out_Valid=0, Result=0 and all flags 0.
REQ-031 In_Ready SHALL be 1 while in reset.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight beats, with no output after release.
REQ-033 On release, the first accepted beat SHALL appear 2 cycles later.

Verification
REQ-034 The bench SHALL cover: Frac=0x8000000, Exp=0x7F, Sign=0 -> Result=0x40000000 two cycles later, flags 0.
REQ-035 The bench SHALL cover: Frac=0x4000000, Exp=0x7F -> 0x3F800000; and Frac=0x0000000 with either sign -> 0x00000000, flags 0.
REQ-036 The bench SHALL cover rounding: Frac=0x4000004 -> 0x3F800000 with Inexact=1 (tie to even); Frac=0x400000C -> 0x3F800002 with Inexact=1.
REQ-037 The bench SHALL cover overflow/underflow: Frac=0x8000000, Exp=0xFE -> 0x7F800000 with Overflow=1; Frac=0x0000008, Exp=0x10 -> 0x00000000 with Underflow=1.
REQ-038 The bench SHALL cover stall: with 3 back-to-back inputs and Out_Ready=0 for 4 cycles -> Out_Valid held with the first result stable and In_Ready=0 once both stages are full; all 3 results emerge in order after Out_Ready=1.
REQ-039 The bench SHALL cover reset mid-stream: assert rst_n=0 with 2 beats in flight -> Out_Valid drops immediately; no stale beat appears after release.
